// File: rtl/nrzi_stuff_encoder.sv
// nrzi_stuff_encoder
//   NRZI line coder with bit stuffing. A 0 input toggles the line level and a
//   1 holds it. After STUFF_LEN consecutive 1s a 0 is inserted and upstream is
//   stalled for that beat. Output is a single registered valid/ready beat.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   up_valid    upstream beat valid
//   up_ready    upstream beat accepted this cycle (combinational from down_ready)
//   up_data     raw data bit
//   up_last     last bit of the packet
//   down_valid  encoded beat valid
//   down_ready  downstream accepts the beat
//   down_data   NRZI line level
//   down_last   final beat of the packet, including a trailing stuff bit
//   stuff_cnt   saturating count of inserted stuff bits
module nrzi_stuff_encoder #(
  parameter int unsigned STUFF_LEN  = 6,
  parameter bit          IDLE_LEVEL = 1'b1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic             up_data,
  input  logic             up_last,
  output logic             down_valid,
  input  logic             down_ready,
  output logic             down_data,
  output logic             down_last,
  output logic [CNT_W-1:0] stuff_cnt
);

  localparam logic [3:0] STUFF_LEN_C = 4'(STUFF_LEN);

  typedef enum logic {S_DATA, S_STUFF} state_t;

  state_t           state, state_nx;
  logic             level, level_nx;
  logic [3:0]       ones_cnt, ones_nx;
  logic             pending_last, pending_last_nx;
  logic             dv_nx, dd_nx, dl_nx;
  logic [CNT_W-1:0] sc_nx;
  logic             load_en;
  logic             bit_level;
  logic [3:0]       bit_ones;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_DATA;
      level        <= IDLE_LEVEL;
      ones_cnt     <= '0;
      pending_last <= 1'b0;
      down_valid   <= 1'b0;
      down_data    <= IDLE_LEVEL;
      down_last    <= 1'b0;
      stuff_cnt    <= '0;
    end else begin
      state        <= state_nx;
      level        <= level_nx;
      ones_cnt     <= ones_nx;
      pending_last <= pending_last_nx;
      down_valid   <= dv_nx;
      down_data    <= dd_nx;
      down_last    <= dl_nx;
      stuff_cnt    <= sc_nx;
    end
  end

  always_comb begin
    load_en         = !down_valid || down_ready;
    up_ready        = load_en && (state == S_DATA);
    state_nx        = state;
    level_nx        = level;
    ones_nx         = ones_cnt;
    pending_last_nx = pending_last;
    dv_nx           = down_valid;
    dd_nx           = down_data;
    dl_nx           = down_last;
    sc_nx           = stuff_cnt;
    bit_level       = up_data ? level : ~level;
    bit_ones        = up_data ? (ones_cnt + 4'd1) : '0;

    if (load_en) begin
      if (state == S_STUFF) begin
        // Stuff beat: inserted 0 toggles the line; closes the packet if the
        // data bit that triggered it was last.
        dv_nx    = 1'b1;
        dd_nx    = ~level;
        dl_nx    = pending_last;
        ones_nx  = '0;
        state_nx = S_DATA;
        level_nx = pending_last ? IDLE_LEVEL : ~level;
        if (stuff_cnt != '1) sc_nx = stuff_cnt + CNT_W'(1);
      end else if (up_valid) begin
        dv_nx = 1'b1;
        dd_nx = bit_level;
        if (bit_ones == STUFF_LEN_C) begin
          // Defer last to the stuff beat; level/run stay live until it goes out.
          state_nx        = S_STUFF;
          pending_last_nx = up_last;
          dl_nx           = 1'b0;
          level_nx        = bit_level;
          ones_nx         = bit_ones;
        end else begin
          dl_nx = up_last;
          if (up_last) begin
            level_nx = IDLE_LEVEL;
            ones_nx  = '0;
          end else begin
            level_nx = bit_level;
            ones_nx  = bit_ones;
          end
        end
      end else begin
        dv_nx = 1'b0;
        dl_nx = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nrzi_stuff_encoder.sv
module tb_nrzi_stuff_encoder;

  localparam int unsigned STUFF_LEN = 6;
  localparam int unsigned CNT_W     = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             up_valid, up_ready, up_data, up_last;
  logic             down_valid, down_ready, down_data, down_last;
  logic [CNT_W-1:0] stuff_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nrzi_stuff_encoder #(.STUFF_LEN(STUFF_LEN), .IDLE_LEVEL(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_last(up_last),
    .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data),
    .down_last(down_last), .stuff_cnt(stuff_cnt)
  );

  typedef struct {
    logic       v, d, l, r;          // up_valid, up_data, up_last, down_ready
    logic       eur;                 // expected up_ready before the edge
    logic       edv, edd, edl;       // expected outputs after the edge
    logic [1:0] esc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, d, l, r, eur, edv, edd, edl, logic [1:0] esc);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = r;
    t.eur = eur; t.edv = edv; t.edd = edd; t.edl = edl; t.esc = esc;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, d, l, r);
    up_valid = v; up_data = d; up_last = l; down_ready = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Reference model: encode a whole packet from the rules
  bit         pkt[$];
  logic [1:0] expq[$];
  logic [1:0] obsq[$];
  int         total_stuff;

  function automatic void encode_pkt();
    bit   stuffed[$];
    int   run;
    logic lvl;
    run = 0;
    foreach (pkt[i]) begin
      stuffed.push_back(pkt[i]);
      run = pkt[i] ? run + 1 : 0;
      if (run == STUFF_LEN) begin
        stuffed.push_back(1'b0);
        run = 0;
        total_stuff++;
      end
    end
    lvl = 1'b1;
    foreach (stuffed[i]) begin
      if (!stuffed[i]) lvl = ~lvl;
      expq.push_back({lvl, logic'(i == stuffed.size() - 1)});
    end
  endfunction

  task automatic rand_cycle(output bit got_last);
    got_last = 1'b0;
    @(negedge clk);
    if (up_valid && up_ready) begin
      pkt.push_back(up_data);
      if (up_last) begin
        encode_pkt();
        pkt.delete();
        got_last = 1'b1;
      end
    end
    if (down_valid && down_ready) obsq.push_back({down_data, down_last});
    tick();
  endtask

  initial begin
    bit got;
    int exp_sc;

    // basic 0,1,0,0
    tbl.push_back(mk(1,0,0,1, 1, 1,0,0, 0));
    tbl.push_back(mk(1,1,0,1, 1, 1,0,0, 0));
    tbl.push_back(mk(1,0,0,1, 1, 1,1,0, 0));
    tbl.push_back(mk(1,0,1,1, 1, 1,0,1, 0));
    // seven 1s, last on 7th
    repeat (6) tbl.push_back(mk(1,1,0,1, 1, 1,1,0, 0));
    tbl.push_back(mk(1,1,1,1, 0, 1,0,0, 1));
    tbl.push_back(mk(1,1,1,1, 1, 1,0,1, 1));
    // six 1s, last on 6th, then single-bit packet of 1
    repeat (5) tbl.push_back(mk(1,1,0,1, 1, 1,1,0, 1));
    tbl.push_back(mk(1,1,1,1, 1, 1,1,0, 1));
    tbl.push_back(mk(0,0,0,1, 0, 1,0,1, 2));
    tbl.push_back(mk(1,1,1,1, 1, 1,1,1, 2));
    // backpressure on 0,1,1
    tbl.push_back(mk(1,0,0,1, 1, 1,0,0, 2));
    repeat (3) tbl.push_back(mk(1,1,0,0, 0, 1,0,0, 2));
    tbl.push_back(mk(1,1,0,1, 1, 1,0,0, 2));
    tbl.push_back(mk(1,1,1,1, 1, 1,0,1, 2));
    tbl.push_back(mk(0,0,0,1, 1, 0,0,0, 2));

    do_reset();
    chk("reset_dv", down_valid, 0);
    chk("reset_dd", down_data, 1);
    chk("reset_dl", down_last, 0);
    chk("reset_sc", stuff_cnt, 0);
    chk("reset_ur", up_ready, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
      #1;
      chk($sformatf("row%0d_ur", i), up_ready, tbl[i].eur);
      tick();
      chk($sformatf("row%0d_dv", i), down_valid, tbl[i].edv);
      chk($sformatf("row%0d_dd", i), down_data, tbl[i].edd);
      if (tbl[i].edv) chk($sformatf("row%0d_dl", i), down_last, tbl[i].edl);
      chk($sformatf("row%0d_sc", i), stuff_cnt, tbl[i].esc);
    end

    // reset while a stuff bit is pending
    drive(1, 1, 0, 1);
    repeat (6) tick();
    chk("pend_ur", up_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_dv", down_valid, 0);
    chk("arst_dd", down_data, 1);
    chk("arst_sc", stuff_cnt, 0);
    drive(0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_dv", down_valid, 0);
    drive(1, 0, 1, 1);
    tick();
    chk("post_rst_dd", down_data, 0);
    chk("post_rst_dv1", down_valid, 1);
    chk("post_rst_sc", stuff_cnt, 0);

    // saturation: five runs of six 1s, each followed by a 0
    do_reset();
    for (int r = 0; r < 5; r++) begin
      drive(1, 1, 0, 1);
      repeat (6) tick();
      drive(1, 0, 0, 1);
      tick();
      chk($sformatf("sat_run%0d", r), stuff_cnt, (r + 1 > 3) ? 3 : r + 1);
      tick();
    end

    // randomized traffic vs packet-level model
    do_reset();
    total_stuff = 0;
    pkt.delete(); expq.delete(); obsq.delete();
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom % 4) != 0, ($urandom % 5) != 0, ($urandom % 16) == 0, ($urandom % 4) != 0);
      rand_cycle(got);
    end
    drive(1, 0, 1, 1);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) rand_cycle(got);
    chk("rand_final_accept", got, 1);
    drive(0, 0, 0, 1);
    for (int c = 0; c < 10; c++) rand_cycle(got);
    chk("rand_beat_count", obsq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < obsq.size(); i++)
      chk($sformatf("rand_beat%0d", i), obsq[i], expq[i]);
    exp_sc = (total_stuff > 3) ? 3 : total_stuff;
    chk("rand_sc", stuff_cnt, exp_sc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
